// File: rtl/m68k_bus_target.sv
// 68000 bus responder: decodes one address window and runs a req/ack transfer to a backing store.
// Define M68K_TARGET_TIMEOUT_EN to terminate unacknowledged cycles with BERR_n after TIMEOUT_CYCLES.
module m68k_bus_target #(
   parameter logic [22:0] BASE_ADDR      = 23'h740000,
   parameter logic [22:0] ADDR_MASK      = 23'h7F8000,
   parameter int unsigned WAIT_STATES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        M68K_CLK,
   input  logic        M68K_RESET_n,
   input  logic [22:0] M68K_A,
   input  logic        M68K_AS_n,
   input  logic        M68K_UDS_n,
   input  logic        M68K_LDS_n,
   input  logic        M68K_RW,
   input  logic [15:0] M68K_D_IN,
   output logic [15:0] M68K_D_OUT,
   output logic        M68K_D_OE,
   output logic        M68K_DTACK_n,
   output logic        M68K_BERR_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [22:0] mem_addr,
   output logic [1:0]  mem_be,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {
      S_IDLE, S_MEM, S_ACK, S_RELEASE, S_IGNORE, S_BERR
   } state_t;

   localparam logic [3:0] WAIT_LIM = 4'(WAIT_STATES);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
`ifdef M68K_TARGET_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       as_p0, uds_p0, lds_p0;
   logic       as_s, uds_s, lds_s;
   state_t     state, state_nxt;
   logic [3:0] wait_cnt;
   logic [7:0] tmo_cnt;
   logic       ack_seen, abort_q, rw_q;
   logic       strobe, hit, abort, tmo_hit;

   // Strobe synchronisers; idle level is high
   always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
      if (!M68K_RESET_n) begin
         as_p0  <= 1'b1;
         uds_p0 <= 1'b1;
         lds_p0 <= 1'b1;
         as_s   <= 1'b1;
         uds_s  <= 1'b1;
         lds_s  <= 1'b1;
      end else begin
         as_p0  <= M68K_AS_n;
         uds_p0 <= M68K_UDS_n;
         lds_p0 <= M68K_LDS_n;
         as_s   <= as_p0;
         uds_s  <= uds_p0;
         lds_s  <= lds_p0;
      end
   end

   assign strobe  = !as_s && (!uds_s || !lds_s);
   assign hit     = (M68K_A & ADDR_MASK) == BASE_ADDR;
   assign abort   = abort_q || as_s;
   // Timeout only fires while no ack has arrived; with the feature off BERRST is unreachable
   assign tmo_hit = TMO_EN && !ack_seen && !mem_ack && (tmo_cnt == TMO_LAST);

   always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
      if (!M68K_RESET_n) state <= S_IDLE;
      else               state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (strobe) state_nxt = hit ? S_MEM : S_IGNORE;
         S_IGNORE:  if (as_s) state_nxt = S_IDLE;
         S_MEM: begin
            // An aborted cycle still waits for the backend so a write commits
            if (ack_seen && abort)                       state_nxt = S_IDLE;
            else if (ack_seen && (wait_cnt >= WAIT_LIM)) state_nxt = S_ACK;
            else if (tmo_hit)                            state_nxt = S_BERR;
         end
         S_ACK:     if (as_s) state_nxt = S_RELEASE;
         S_BERR:    if (as_s) state_nxt = S_RELEASE;
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
      if (!M68K_RESET_n) begin
         M68K_D_OUT   <= 16'h0000;
         M68K_D_OE    <= 1'b0;
         M68K_DTACK_n <= 1'b1;
         M68K_BERR_n  <= 1'b1;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 23'h0;
         mem_be       <= 2'b00;
         mem_wdata    <= 16'h0000;
         wait_cnt     <= 4'h0;
         tmo_cnt      <= 8'h00;
         ack_seen     <= 1'b0;
         abort_q      <= 1'b0;
         rw_q         <= 1'b1;
      end else begin
         if (state == S_IDLE) begin
            wait_cnt <= 4'h0;
            tmo_cnt  <= 8'h00;
            ack_seen <= 1'b0;
            abort_q  <= 1'b0;
            if (strobe) begin
               mem_addr <= M68K_A;
               mem_we   <= !M68K_RW;
               rw_q     <= M68K_RW;
               mem_be   <= {!uds_s, !lds_s};
               if (!M68K_RW) mem_wdata <= M68K_D_IN;
            end
         end

         if (state == S_MEM) begin
            if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'h1;
            tmo_cnt <= tmo_cnt + 8'h01;
            if (as_s) abort_q <= 1'b1;
            if (mem_ack) begin
               ack_seen <= 1'b1;
               if (rw_q) M68K_D_OUT <= mem_rdata;
            end
         end

         // Request rises on window hit and falls the cycle after the ack or on timeout
         case (state)
            S_IDLE:  mem_req <= (state_nxt == S_MEM);
            S_MEM:   mem_req <= mem_req && !mem_ack && (state_nxt == S_MEM);
            default: mem_req <= 1'b0;
         endcase

         M68K_DTACK_n <= !(state_nxt == S_ACK);
         M68K_D_OE    <= (state_nxt == S_ACK) && rw_q;
         M68K_BERR_n  <= !(state_nxt == S_BERR);
      end
   end

endmodule
